// File: rtl/palette_layer_sched_pkg.sv
// Shared types and constants for the palette layer scheduler.
package palette_pkg;

    typedef enum logic [2:0] {
        SEL_SPRITE   = 3'd0,
        SEL_MAP      = 3'd1,
        SEL_GYM      = 3'd2,
        SEL_START    = 3'd3,
        SEL_DIALOGUE = 3'd4,
        SEL_BLACK    = 3'd5
    } sel_t;

    typedef enum logic [1:0] {
        SCENE_MAP   = 2'd0,
        SCENE_GYM   = 2'd1,
        SCENE_START = 2'd2
    } scene_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FADE_OUT,
        ST_BLACK,
        ST_FADE_IN,
        ST_SWITCH
    } state_t;

    localparam logic [3:0] SPRITE_KEY_IDX = 4'd0;
    localparam logic [3:0] FADE_MAX       = 4'd15;

    function automatic sel_t scene_sel(input scene_t s);
        case (s)
            SCENE_MAP: return SEL_MAP;
            SCENE_GYM: return SEL_GYM;
            default:   return SEL_START;
        endcase
    endfunction

endpackage

// File: rtl/palette_layer_sched_if.sv
// Per-pixel layer inputs and registered palette lookup outputs.
interface palette_layer_sched_if;
    logic       pix_valid;
    logic       sprite_hit;
    logic [3:0] sprite_idx;
    logic [7:0] map_idx;
    logic [5:0] gym_idx;
    logic [4:0] start_idx;
    logic       dlg_active;
    logic       dlg_idx;
    logic       out_valid;
    logic [2:0] select;
    logic [3:0] palette_color;
    logic [7:0] map_palette_color;
    logic [5:0] gym_palette_color;
    logic [4:0] start_palette_color;
    logic       dialogue_palette_color;

    modport slave (
        input  pix_valid, sprite_hit, sprite_idx, map_idx, gym_idx, start_idx, dlg_active, dlg_idx,
        output out_valid, select, palette_color, map_palette_color, gym_palette_color,
               start_palette_color, dialogue_palette_color
    );

    modport master (
        output pix_valid, sprite_hit, sprite_idx, map_idx, gym_idx, start_idx, dlg_active, dlg_idx,
        input  out_valid, select, palette_color, map_palette_color, gym_palette_color,
               start_palette_color, dialogue_palette_color
    );
endinterface

// File: rtl/palette_layer_sched_fade_timer.sv
// Frame-pulse divider and saturating brightness counter; present only when PALETTE_FADE_EN is defined.
`ifdef PALETTE_FADE_EN
module fade_timer
    import palette_pkg::*;
#(
    parameter int unsigned FADE_STEP_FRAMES = 2,
    parameter int unsigned BLACK_FRAMES     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       frame_start,
    input  logic       black,
    input  logic       level_dn,
    input  logic       level_up,
    output logic       tick,
    output logic [3:0] level
);
    logic [15:0] cnt;
    logic [15:0] term;

    // One divider serves both the fade step period and the black hold period.
    assign term = black ? 16'(BLACK_FRAMES - 1) : 16'(FADE_STEP_FRAMES - 1);
    assign tick = frame_start && (cnt == term);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (frame_start) begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= FADE_MAX;
        end else if (level_dn && level != '0) begin
            level <= level - 4'd1;
        end else if (level_up && level != FADE_MAX) begin
            level <= level + 4'd1;
        end
    end
endmodule
`endif

// File: rtl/palette_layer_sched.sv
// Per-pixel palette layer select, active-scene ownership and scene-change sequencing.
// Build option: define PALETTE_FADE_EN for the frame-paced fade-out / black / fade-in sequence.
module palette_layer_sched
    import palette_pkg::*;
#(
    parameter int unsigned FADE_STEP_FRAMES = 2,
    parameter int unsigned BLACK_FRAMES     = 4,
    parameter int unsigned RESET_SCENE      = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_start,
    input  logic                 scene_req,
    input  logic [1:0]           scene_next,
    output logic                 scene_ack,
    output logic                 busy,
    output logic [1:0]           scene_cur,
    output logic [3:0]           fade_level,
    palette_layer_sched_if.slave pix
);
    localparam scene_t RST_SCENE = scene_t'(2'(RESET_SCENE));

    if (FADE_STEP_FRAMES < 1 || BLACK_FRAMES < 1 || RESET_SCENE > 2) begin : g_bad_cfg
        $error("palette_layer_sched: invalid parameter value");
    end

    state_t state, state_next;
    scene_t scene_q, scene_d, pending_q, pending_d;
    logic   ack_d, accept, in_black;
    sel_t   sel_d;

    assign accept    = scene_req && (scene_next != 2'd3);
    assign scene_cur = scene_q;

`ifdef PALETTE_FADE_EN
    logic tick, timer_clear, level_dn, level_up;

    assign in_black = (state == ST_BLACK);
    // Divider restarts on every state entry and stays idle outside a transition.
    assign timer_clear = (state_next != state) || (state == ST_IDLE);

    fade_timer #(
        .FADE_STEP_FRAMES(FADE_STEP_FRAMES),
        .BLACK_FRAMES    (BLACK_FRAMES)
    ) u_fade_timer (
        .clk        (Clk),
        .rst        (Reset),
        .clear      (timer_clear),
        .frame_start(frame_start),
        .black      (in_black),
        .level_dn   (level_dn),
        .level_up   (level_up),
        .tick       (tick),
        .level      (fade_level)
    );
`else
    assign in_black   = 1'b0;
    assign fade_level = FADE_MAX;
`endif

    always_comb begin
        state_next = state;
        scene_d    = scene_q;
        pending_d  = pending_q;
        ack_d      = 1'b0;
`ifdef PALETTE_FADE_EN
        level_dn   = 1'b0;
        level_up   = 1'b0;
`endif
        case (state)
            ST_IDLE: if (accept) begin
                pending_d = scene_t'(scene_next);
`ifdef PALETTE_FADE_EN
                state_next = ST_FADE_OUT;
`else
                state_next = ST_SWITCH;
`endif
            end
`ifdef PALETTE_FADE_EN
            ST_FADE_OUT: if (tick) begin
                if (fade_level == '0) begin
                    state_next = ST_BLACK;
                    scene_d    = pending_q;
                end else begin
                    level_dn = 1'b1;
                end
            end
            ST_BLACK: if (tick) state_next = ST_FADE_IN;
            ST_FADE_IN: if (tick) begin
                if (fade_level == FADE_MAX) begin
                    state_next = ST_IDLE;
                    ack_d      = 1'b1;
                end else begin
                    level_up = 1'b1;
                end
            end
`else
            ST_SWITCH: if (frame_start) begin
                state_next = ST_IDLE;
                scene_d    = pending_q;
                ack_d      = 1'b1;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            scene_q   <= RST_SCENE;
            pending_q <= RST_SCENE;
            scene_ack <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            scene_q   <= scene_d;
            pending_q <= pending_d;
            scene_ack <= ack_d;
            busy      <= (state_next != ST_IDLE);
        end
    end

    always_comb begin
        sel_d = scene_sel(scene_q);
        if (!pix.pix_valid || in_black) begin
            sel_d = SEL_BLACK;
        end else if (pix.dlg_active) begin
            sel_d = SEL_DIALOGUE;
        end else if (pix.sprite_hit && pix.sprite_idx != SPRITE_KEY_IDX) begin
            sel_d = SEL_SPRITE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix.out_valid              <= 1'b0;
            pix.select                 <= '0;
            pix.palette_color          <= '0;
            pix.map_palette_color      <= '0;
            pix.gym_palette_color      <= '0;
            pix.start_palette_color    <= '0;
            pix.dialogue_palette_color <= 1'b0;
        end else begin
            pix.out_valid              <= pix.pix_valid;
            pix.select                 <= sel_d;
            pix.palette_color          <= pix.sprite_idx;
            pix.map_palette_color      <= pix.map_idx;
            pix.gym_palette_color      <= pix.gym_idx;
            pix.start_palette_color    <= pix.start_idx;
            pix.dialogue_palette_color <= pix.dlg_idx;
        end
    end
endmodule

// File: tb/tb_palette_layer_sched.sv
// Scoreboard bench for palette_layer_sched; covers either build of PALETTE_FADE_EN.
module tb_palette_layer_sched;
`ifdef PALETTE_FADE_EN
    localparam int unsigned STEP = 1;
    localparam int unsigned BLK  = 2;
`else
    localparam int unsigned STEP = 2;
    localparam int unsigned BLK  = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       scene_req = 1'b0;
    logic [1:0] scene_next = 2'd0;
    logic       scene_ack, busy;
    logic [1:0] scene_cur;
    logic [3:0] fade_level;

    palette_layer_sched_if pif ();

    palette_layer_sched #(
        .FADE_STEP_FRAMES(STEP),
        .BLACK_FRAMES    (BLK),
        .RESET_SCENE     (2)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .frame_start(frame_start),
        .scene_req  (scene_req),
        .scene_next (scene_next),
        .scene_ack  (scene_ack),
        .busy       (busy),
        .scene_cur  (scene_cur),
        .fade_level (fade_level),
        .pix        (pif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          tag;
        bit          pix;
        bit          ctl;
        logic [27:0] pix_v;
        logic [7:0]  ctl_v;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   ack_cov;
    logic [27:0] act_pix;
    logic [7:0]  act_ctl;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation that falls due on this edge.
    always @(posedge clk) begin
        #1;
        ack_cov = 1'b0;
        act_pix = {pif.out_valid, pif.select, pif.palette_color, pif.map_palette_color,
                   pif.gym_palette_color, pif.start_palette_color, pif.dialogue_palette_color};
        act_ctl = {scene_cur, busy, fade_level, scene_ack};
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            me = sb.pop_front();
            if (me.due != cyc) begin
                checks++;
                errors++;
                $display("FAIL stale tag=%0d due=%0d now=%0d", me.tag, me.due, cyc);
            end else begin
                if (me.pix) begin
                    checks++;
                    if (act_pix !== me.pix_v) begin
                        errors++;
                        $display("FAIL pix tag=%0d got=%h exp=%h", me.tag, act_pix, me.pix_v);
                    end
                end
                if (me.ctl) begin
                    ack_cov = 1'b1;
                    checks++;
                    if (act_ctl !== me.ctl_v) begin
                        errors++;
                        $display("FAIL ctl tag=%0d got{scn,busy,fade,ack}=%h exp=%h", me.tag, act_ctl, me.ctl_v);
                    end
                end
            end
        end
        if (!ack_cov) begin
            checks++;
            if (scene_ack !== 1'b0) begin
                errors++;
                $display("FAIL spurious_ack cyc=%0d got=%b exp=0", cyc, scene_ack);
            end
        end
    end

    task automatic push(input int tag, input bit p, input logic [27:0] pv, input bit c, input logic [7:0] cv);
        exp_t e;
        e.due   = cyc + 1;
        e.tag   = tag;
        e.pix   = p;
        e.ctl   = c;
        e.pix_v = pv;
        e.ctl_v = cv;
        sb.push_back(e);
    endtask

    task automatic ctl(input int tag, input logic fs, input logic req, input logic [1:0] nxt,
                       input logic [1:0] scn, input logic bsy, input logic [3:0] fl, input logic ack);
        @(negedge clk);
        frame_start = fs;
        scene_req   = req;
        scene_next  = nxt;
        push(tag, 1'b0, '0, 1'b1, {scn, bsy, fl, ack});
    endtask

    task automatic pix(input int tag, input logic v, input logic hit, input logic [3:0] sidx,
                       input logic [7:0] midx, input logic [5:0] gidx, input logic [4:0] stidx,
                       input logic dlg, input logic didx, input logic [2:0] esel);
        @(negedge clk);
        frame_start        = 1'b0;
        scene_req          = 1'b0;
        pif.pix_valid      = v;
        pif.sprite_hit     = hit;
        pif.sprite_idx     = sidx;
        pif.map_idx        = midx;
        pif.gym_idx        = gidx;
        pif.start_idx      = stidx;
        pif.dlg_active     = dlg;
        pif.dlg_idx        = didx;
        push(tag, 1'b1, {v, esel, sidx, midx, gidx, stidx, didx}, 1'b0, '0);
    endtask

    task automatic do_reset(input int tag);
        @(negedge clk);
        rst         = 1'b1;
        frame_start = 1'b0;
        scene_req   = 1'b0;
        push(tag, 1'b1, '0, 1'b1, {2'd2, 1'b0, 4'd15, 1'b0});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        pif.pix_valid  = 1'b1;
        pif.sprite_hit = 1'b1;
        pif.sprite_idx = 4'd9;
        pif.map_idx    = 8'h3C;
        pif.gym_idx    = 6'h15;
        pif.start_idx  = 5'h0A;
        pif.dlg_active = 1'b0;
        pif.dlg_idx    = 1'b1;
        repeat (2) @(negedge clk);
        do_reset(1);

        // Layer priority with scene_cur = start
        pix(10, 1, 1, 4'd5, 8'hA5, 6'h2A, 5'h13, 1, 1, 3'd4);
        pix(11, 1, 1, 4'd5, 8'hA5, 6'h2A, 5'h13, 0, 1, 3'd0);
        pix(12, 1, 1, 4'd0, 8'h5A, 6'h11, 5'h1F, 0, 0, 3'd3);
        pix(13, 1, 0, 4'd7, 8'hFF, 6'h3F, 5'h01, 0, 1, 3'd3);
        pix(14, 0, 1, 4'd5, 8'h01, 6'h02, 5'h03, 1, 1, 3'd5);
        pix(15, 1, 0, 4'd0, 8'h80, 6'h20, 5'h10, 1, 0, 3'd4);

        ctl(20, 0, 0, 2'd0, 2'd2, 0, 4'd15, 0);
        ctl(21, 0, 1, 2'd3, 2'd2, 0, 4'd15, 0);
        ctl(22, 0, 0, 2'd0, 2'd2, 0, 4'd15, 0);

`ifdef PALETTE_FADE_EN
        ctl(100, 0, 1, 2'd0, 2'd2, 1, 4'd15, 0);
        for (int k = 1; k <= 15; k++) begin
            ctl(100 + k, 1, 0, 2'd0, 2'd2, 1, 4'(15 - k), 0);
            if (k == 5) ctl(150, 0, 1, 2'd1, 2'd2, 1, 4'(15 - k), 0);
            else        ctl(120 + k, 0, 0, 2'd0, 2'd2, 1, 4'(15 - k), 0);
        end
        ctl(160, 1, 0, 2'd0, 2'd0, 1, 4'd0, 0);
        pix(161, 1, 1, 4'd5, 8'h12, 6'h34, 5'h05, 1, 1, 3'd5);
        ctl(162, 1, 0, 2'd0, 2'd0, 1, 4'd0, 0);
        ctl(163, 0, 0, 2'd0, 2'd0, 1, 4'd0, 0);
        ctl(164, 1, 0, 2'd0, 2'd0, 1, 4'd0, 0);
        pix(165, 1, 1, 4'd5, 8'h12, 6'h34, 5'h05, 1, 1, 3'd4);
        for (int k = 1; k <= 15; k++) begin
            ctl(200 + k, 1, 0, 2'd0, 2'd0, 1, 4'(k), 0);
            ctl(220 + k, 0, 0, 2'd0, 2'd0, 1, 4'(k), 0);
        end
        ctl(240, 1, 0, 2'd0, 2'd0, 0, 4'd15, 1);
        ctl(241, 0, 0, 2'd0, 2'd0, 0, 4'd15, 0);
        pix(242, 1, 0, 4'd3, 8'h77, 6'h01, 5'h02, 0, 0, 3'd1);

        // Reset while holding black
        ctl(300, 0, 1, 2'd1, 2'd0, 1, 4'd15, 0);
        for (int k = 1; k <= 15; k++) ctl(300 + k, 1, 0, 2'd0, 2'd0, 1, 4'(15 - k), 0);
        ctl(320, 1, 0, 2'd0, 2'd1, 1, 4'd0, 0);
        ctl(321, 1, 0, 2'd0, 2'd1, 1, 4'd0, 0);
        do_reset(322);
        for (int k = 0; k < 3; k++) ctl(330 + k, 1, 0, 2'd0, 2'd2, 0, 4'd15, 0);
`else
        // Request with coincident frame_start: that pulse must not complete it
        ctl(100, 1, 1, 2'd1, 2'd2, 1, 4'd15, 0);
        ctl(101, 0, 0, 2'd0, 2'd2, 1, 4'd15, 0);
        ctl(102, 0, 1, 2'd0, 2'd2, 1, 4'd15, 0);
        for (int k = 0; k < 7; k++) ctl(110 + k, 0, 0, 2'd0, 2'd2, 1, 4'd15, 0);
        ctl(120, 1, 0, 2'd0, 2'd1, 0, 4'd15, 1);
        ctl(121, 0, 0, 2'd0, 2'd1, 0, 4'd15, 0);
        pix(122, 1, 0, 4'd2, 8'h44, 6'h09, 5'h0C, 0, 1, 3'd2);
        ctl(130, 0, 1, 2'd0, 2'd1, 1, 4'd15, 0);
        ctl(131, 1, 0, 2'd0, 2'd0, 0, 4'd15, 1);
        pix(132, 1, 1, 4'd0, 8'h66, 6'h0F, 5'h0E, 0, 0, 3'd1);
        ctl(140, 0, 1, 2'd1, 2'd0, 1, 4'd15, 0);
        do_reset(141);
        ctl(142, 1, 0, 2'd0, 2'd2, 0, 4'd15, 0);
        ctl(143, 0, 0, 2'd0, 2'd2, 0, 4'd15, 0);
`endif

        @(negedge clk);
        frame_start = 1'b0;
        scene_req   = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d pending exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
